uart_frame_tx_ctrl: RTL and testbench
=====================================

// Module: uart_frame_tx_ctrl
// PURPOSE
//  Multi-channel successor to the UART transmit controller. On each valid ADC conversion it snapshots CH_NUM results.
//  It streams them to the UART byte transmitter as a framed packet, one byte per Byte_En/Tx_Done handshake.
//  It sits between the ADC capture logic and the UART byte TX. Host register writes set enable, baud, channel mask and overrun clear.
// PARAMETERS
//  CH_NUM      4      number of ADC channels, 1..8
//  DATA_W      12     bits per channel sample, 1..16, zero-extended to 16 on the wire
//  HDR_BYTE    8'hA5  frame start byte
// PORTS
//  Clk        in   1                  system clock
//  Rst_n      in   1                  asynchronous active-low reset
//  m_wr       in   1                  host register write strobe
//  m_addr     in   8                  host register address
//  m_wrdata   in   16                 host register write data
//  ADC_Flag   in   1                  1-cycle pulse: ADC_Data valid
//  ADC_Data   in   CH_NUM*DATA_W      channel i at [i*DATA_W +: DATA_W]
//  Tx_Done    in   1                  1-cycle pulse: UART byte sent
//  Byte_En    out  1                  1-cycle pulse: start sending Tx_Data
//  Tx_Data    out  8                  byte to send, held stable until next Byte_En
//  Baud_Set   out  3                  baud select to UART TX
//  Busy       out  1                  frame in progress
//  Overrun    out  1                  sticky: ADC_Flag arrived while Busy
// BEHAVIOUR
//  Registers (written when m_wr=1 at matching m_addr):
//   8'd4 En_Tx<=wrdata[0], reset 1; 8'd5 reg_Baud<=wrdata[2:0], reset 0 (9600); 8'd6 Ch_Mask<=wrdata[CH_NUM-1:0], reset all 1s;
//   8'd7 wrdata[0]=1 clears Overrun.
//  Reset values: Byte_En=0, Tx_Data=0, Baud_Set=0, Busy=0, Overrun=0, FSM=IDLE, byte index=0.
//  Frame: HDR_BYTE, then for each set mask bit in ascending i: {hi,lo} bytes of 16-bit zero-extended sample, then optional checksum.
//   Length = 1 + 2*popcount(mask) [+1].
//  FSM IDLE -> SEND -> WAIT -> (SEND | IDLE).
//   IDLE: on clock edge with ADC_Flag=1 and En_Tx=1: latch ADC_Data and Ch_Mask, Baud_Set<=reg_Baud, Busy<=1, go SEND.
//   SEND: Byte_En<=1 for exactly one cycle, Tx_Data<=current byte; go WAIT. First Byte_En appears 2 cycles after ADC_Flag.
//   WAIT: on Tx_Done: last byte or En_Tx=0 -> IDLE, Busy<=0; else advance index to next enabled byte -> SEND.
//   Tx_Done outside WAIT is ignored.
//  En_Tx cleared mid-frame: the byte in flight completes; no further bytes; no checksum is sent.
//  ADC_Flag while Busy (including on the Tx_Done edge of the last byte): sample dropped, Overrun<=1. Set wins over a same-cycle clear.
//  ADC_Flag with En_Tx=0: ignored, Overrun unchanged.
//  Baud, mask and data writes mid-frame take effect only at the next frame start. Latched data is immune to ADC_Data changes.
//  Ch_Mask=0: frame is the header only (+checksum).
//  Reset asserted mid-frame: immediate return to reset values; the partially sent frame is abandoned.
// CONFIGURATION
//  UART_FRAME_CKSUM_EN defined: a final byte follows the data bytes. It is the 8-bit sum mod 256 of all preceding frame bytes, header included.
//  UART_FRAME_CKSUM_EN undefined: frame ends after the last data byte; no accumulator logic.
// STRUCTURE
//  Shared package uart_frame_pkg holds:
//   - register address constants UART_En_Tx=4, UART_Baud_Set=5, UART_Ch_Mask=6, UART_Stat_Clr=7;
//   - FSM state encoding IDLE/SEND/WAIT;
//   - default HDR_BYTE.
//  One sub-module, uart_frame_byte_sel: combinational next-enabled-byte finder. Inputs are index and latched mask; outputs are byte value and last flag.
// TESTING (CH_NUM=4, DATA_W=12, checksum enabled unless noted)
//  1 Release reset, no writes -> Byte_En=0, Tx_Data=0, Baud_Set=0, Busy=0, Overrun=0; En_Tx=1, mask=4'hF.
//  2 mask=4'b0101, ch0=12'hABC, ch2=12'h123, ADC_Flag; bench answers Tx_Done 10 cycles after each Byte_En.
//    -> bytes A5,0A,BC,01,23,8F in order, one Byte_En each, then Busy=0.
//  3 ADC_Flag pulsed during byte 3 of test 2 -> Overrun=1, frame bytes unchanged. Write 8'd7=1 -> Overrun=0.
//    A same-cycle ADC_Flag+clear while Busy -> Overrun stays 1.
//  4 Write baud=3 after byte 1 -> Baud_Set stays 0 for that frame; next frame start -> Baud_Set=3.
//  5 Write En_Tx=0 during byte 2 wait -> Tx_Done ends the frame, no byte 3, Busy=0; a later ADC_Flag produces no Byte_En.
//  6 mask=0, ADC_Flag -> A5 then A5 (checksum); without UART_FRAME_CKSUM_EN -> single A5.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared register map, FSM encoding and header default for uart_frame_tx_ctrl
package uart_frame_pkg;

    localparam logic [7:0] UART_En_Tx    = 8'd4;
    localparam logic [7:0] UART_Baud_Set = 8'd5;
    localparam logic [7:0] UART_Ch_Mask  = 8'd6;
    localparam logic [7:0] UART_Stat_Clr = 8'd7;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } frame_state_e;

endpackage

// File: rtl/uart_frame_byte_sel.sv
// rtl/uart_frame_byte_sel.sv - combinational frame byte lookup and next-enabled-byte finder (UART_FRAME_CKSUM_EN adds checksum slot)
module uart_frame_byte_sel
    import uart_frame_pkg::*;
#(
    parameter int         CH_NUM   = 4,
    parameter int         DATA_W   = 12,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT,
    parameter int         IDX_W    = $clog2(2 * CH_NUM + 2)
) (
    input  logic [IDX_W-1:0]         idx,
    input  logic [CH_NUM-1:0]        mask,
    input  logic [CH_NUM*DATA_W-1:0] data,
    input  logic [7:0]               cksum,
    output logic [7:0]               byte_val,
    output logic [IDX_W-1:0]         next_idx,
    output logic                     last
);

    // Byte slots: 0 = header, 2i+1/2i+2 = hi/lo of channel i, 2*CH_NUM+1 = checksum
    localparam int CK_IDX = 2 * CH_NUM + 1;

    int          ix;
    int          cand;
    logic [15:0] sample;

    always_comb begin
        ix     = int'(idx);
        sample = '0;
        cand   = 0;
        last   = 1'b1;
        for (int i = 0; i < CH_NUM; i++) begin
            if (ix == 2 * i + 1 || ix == 2 * i + 2) begin
                sample = 16'(data[i*DATA_W +: DATA_W]);
            end
        end
        if (ix == 0) begin
            byte_val = HDR_BYTE;
        end else if (ix > 2 * CH_NUM) begin
            byte_val = cksum;
        end else begin
            byte_val = idx[0] ? sample[15:8] : sample[7:0];
        end
`ifdef UART_FRAME_CKSUM_EN
        if (CK_IDX > ix) begin
            cand = CK_IDX;
            last = 1'b0;
        end
`endif
        // Walk channels downward so the lowest enabled slot above idx wins
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i]) begin
                if (2 * i + 2 > ix) begin
                    cand = 2 * i + 2;
                    last = 1'b0;
                end
                if (2 * i + 1 > ix) begin
                    cand = 2 * i + 1;
                    last = 1'b0;
                end
            end
        end
        next_idx = IDX_W'(cand);
    end

endmodule

// File: rtl/uart_frame_tx_ctrl.sv
// rtl/uart_frame_tx_ctrl.sv - multi-channel ADC snapshot framer feeding a UART byte TX (UART_FRAME_CKSUM_EN appends checksum)
module uart_frame_tx_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         CH_NUM   = 4,
    parameter int         DATA_W   = 12,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     m_wr,
    input  logic [7:0]               m_addr,
    input  logic [15:0]              m_wrdata,
    input  logic                     ADC_Flag,
    input  logic [CH_NUM*DATA_W-1:0] ADC_Data,
    input  logic                     Tx_Done,
    output logic                     Byte_En,
    output logic [7:0]               Tx_Data,
    output logic [2:0]               Baud_Set,
    output logic                     Busy,
    output logic                     Overrun
);

    localparam int IDX_W = $clog2(2 * CH_NUM + 2);

    frame_state_e state, state_nxt;

    logic                     en_tx;
    logic [2:0]               reg_baud;
    logic [CH_NUM-1:0]        ch_mask;
    logic [CH_NUM-1:0]        mask_lat;
    logic [CH_NUM*DATA_W-1:0] data_lat;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         next_idx;
    logic [7:0]               cur_byte;
    logic [7:0]               cksum;
    logic                     last;
    logic                     start, send, finish, advance;

    uart_frame_byte_sel #(
        .CH_NUM   (CH_NUM),
        .DATA_W   (DATA_W),
        .HDR_BYTE (HDR_BYTE),
        .IDX_W    (IDX_W)
    ) u_byte_sel (
        .idx      (idx),
        .mask     (mask_lat),
        .data     (data_lat),
        .cksum    (cksum),
        .byte_val (cur_byte),
        .next_idx (next_idx),
        .last     (last)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        send      = 1'b0;
        finish    = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (ADC_Flag && en_tx) begin
                    start     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                send      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (Tx_Done) begin
                    // A disabled transmitter stops after the byte in flight, checksum included
                    if (last || !en_tx) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            en_tx    <= 1'b1;
            reg_baud <= 3'd0;
            ch_mask  <= '1;
            Overrun  <= 1'b0;
        end else begin
            if (m_wr && m_addr == UART_En_Tx)    en_tx    <= m_wrdata[0];
            if (m_wr && m_addr == UART_Baud_Set) reg_baud <= m_wrdata[2:0];
            if (m_wr && m_addr == UART_Ch_Mask)  ch_mask  <= m_wrdata[CH_NUM-1:0];
            if (ADC_Flag && en_tx && Busy) begin
                Overrun <= 1'b1;
            end else if (m_wr && m_addr == UART_Stat_Clr && m_wrdata[0]) begin
                Overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Byte_En  <= 1'b0;
            Tx_Data  <= 8'h00;
            Baud_Set <= 3'd0;
            Busy     <= 1'b0;
            mask_lat <= '0;
            data_lat <= '0;
            idx      <= '0;
        end else begin
            Byte_En <= 1'b0;
            if (start) begin
                data_lat <= ADC_Data;
                mask_lat <= ch_mask;
                Baud_Set <= reg_baud;
                Busy     <= 1'b1;
                idx      <= '0;
            end
            if (send) begin
                Byte_En <= 1'b1;
                Tx_Data <= cur_byte;
            end
            if (advance) idx  <= next_idx;
            if (finish)  Busy <= 1'b0;
        end
    end

`ifdef UART_FRAME_CKSUM_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cksum <= 8'h00;
        end else if (start) begin
            cksum <= 8'h00;
        end else if (send) begin
            cksum <= cksum + cur_byte;
        end
    end
`else
    assign cksum = 8'h00;
`endif

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// tb/tb_uart_frame_tx_ctrl.sv - directed scoreboard bench for uart_frame_tx_ctrl
module tb_uart_frame_tx_ctrl;

    localparam int CH_NUM = 4;
    localparam int DATA_W = 12;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        m_wr = 1'b0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wrdata = 16'h0000;
    logic        ADC_Flag = 1'b0;
    logic [47:0] ADC_Data = '0;
    logic        Tx_Done = 1'b0;
    logic        Byte_En;
    logic [7:0]  Tx_Data;
    logic [2:0]  Baud_Set;
    logic        Busy;
    logic        Overrun;

    int         total = 0;
    int         bad = 0;
    int         byte_cnt = 0;
    int         base = 0;
    logic [7:0] exp_q[$];
    logic [3:0] cur_mask = 4'hF;

    uart_frame_tx_ctrl #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .HDR_BYTE(8'hA5)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wrdata (m_wrdata),
        .ADC_Flag (ADC_Flag),
        .ADC_Data (ADC_Data),
        .Tx_Done  (Tx_Done),
        .Byte_En  (Byte_En),
        .Tx_Data  (Tx_Data),
        .Baud_Set (Baud_Set),
        .Busy     (Busy),
        .Overrun  (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [3:0] mask, input logic [47:0] d);
        logic [7:0]  sum;
        logic [15:0] s;
        sum = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < CH_NUM; i++) begin
            if (mask[i]) begin
                s = {4'h0, d[i*DATA_W +: DATA_W]};
                exp_q.push_back(s[15:8]);
                exp_q.push_back(s[7:0]);
                sum = sum + s[15:8] + s[7:0];
            end
        end
`ifdef UART_FRAME_CKSUM_EN
        exp_q.push_back(sum);
`endif
    endfunction

    // Scoreboard: every Byte_En must match the next expected byte
    always @(negedge Clk) begin
        if (Rst_n && Byte_En === 1'b1) begin
            byte_cnt++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_byte observed=%0h expected=none", Tx_Data);
            end
            if (exp_q.size() != 0) chk("frame_byte", {8'h00, Tx_Data}, {8'h00, exp_q.pop_front()});
        end
    end

    // UART byte transmitter model: Tx_Done 10 cycles after each Byte_En
    always begin
        @(negedge Clk);
        if (Rst_n && Byte_En === 1'b1) begin
            repeat (10) @(negedge Clk);
            Tx_Done = 1'b1;
            @(negedge Clk);
            Tx_Done = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        @(negedge Clk);
        m_wr = 1'b1; m_addr = a; m_wrdata = d;
        @(negedge Clk);
        m_wr = 1'b0;
    endtask

    task automatic adc(input logic [47:0] d, input bit push);
        @(negedge Clk);
        ADC_Flag = 1'b1; ADC_Data = d;
        if (push) push_frame(cur_mask, d);
        @(negedge Clk);
        ADC_Flag = 1'b0; ADC_Data = ~d;
    endtask

    task automatic wait_bytes(input int n);
        int k;
        k = 0;
        while (byte_cnt < n && k < 300) begin
            @(negedge Clk);
            k++;
        end
        chk("wait_bytes_timeout", 16'(byte_cnt >= n), 16'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((Busy !== 1'b0 || exp_q.size() != 0) && k < 500) begin
            @(negedge Clk);
            k++;
        end
        chk({tag, "_busy"}, {15'd0, Busy}, 16'd0);
        chk({tag, "_pending"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        tick(3);
        Rst_n = 1'b1;
        tick(1);
        chk("rst_byte_en", {15'd0, Byte_En}, 16'd0);
        chk("rst_tx_data", {8'd0, Tx_Data}, 16'd0);
        chk("rst_baud", {13'd0, Baud_Set}, 16'd0);
        chk("rst_busy", {15'd0, Busy}, 16'd0);
        chk("rst_overrun", {15'd0, Overrun}, 16'd0);

        // Default enable and full mask, with first-byte latency
        adc({12'h111, 12'h222, 12'h333, 12'h444}, 1'b1);
        chk("start_busy", {15'd0, Busy}, 16'd1);
        chk("start_no_byte_yet", {15'd0, Byte_En}, 16'd0);
        @(negedge Clk);
        chk("first_byte_lat", {15'd0, Byte_En}, 16'd1);
        wait_idle("full_mask");

        // Mask 0101 frame with an ADC_Flag during byte 3
        wr(8'd6, 16'h0005);
        cur_mask = 4'h5;
        base = byte_cnt;
        adc({12'h000, 12'h123, 12'h000, 12'hABC}, 1'b1);
        wait_bytes(base + 3);
        adc(48'hFFF_FFF_FFF_FFF, 1'b0);
        chk("overrun_set", {15'd0, Overrun}, 16'd1);
        wait_idle("mask5");
        chk("overrun_sticky", {15'd0, Overrun}, 16'd1);
        wr(8'd7, 16'h0001);
        chk("overrun_clr", {15'd0, Overrun}, 16'd0);

        // Same-cycle set and clear while busy: set wins
        base = byte_cnt;
        adc({12'h000, 12'h456, 12'h000, 12'h789}, 1'b1);
        wait_bytes(base + 1);
        @(negedge Clk);
        ADC_Flag = 1'b1; m_wr = 1'b1; m_addr = 8'd7; m_wrdata = 16'h0001;
        @(negedge Clk);
        ADC_Flag = 1'b0; m_wr = 1'b0;
        chk("overrun_set_wins", {15'd0, Overrun}, 16'd1);
        wait_idle("set_wins");
        wr(8'd7, 16'h0001);
        chk("overrun_clr2", {15'd0, Overrun}, 16'd0);

        // Baud and mask writes mid-frame apply at the next frame
        base = byte_cnt;
        adc({12'h000, 12'hFED, 12'h000, 12'h0A5}, 1'b1);
        wait_bytes(base + 1);
        wr(8'd5, 16'h0003);
        wr(8'd6, 16'h000A);
        cur_mask = 4'hA;
        chk("baud_hold_mid", {13'd0, Baud_Set}, 16'd0);
        wait_idle("baud_frame");
        chk("baud_hold_end", {13'd0, Baud_Set}, 16'd0);
        adc({12'hC0D, 12'h000, 12'hE0F, 12'h000}, 1'b1);
        chk("baud_next_frame", {13'd0, Baud_Set}, 16'd3);
        wait_idle("mask_a");

        // En_Tx cleared during byte 2: frame stops after byte 2
        base = byte_cnt;
        adc({12'h321, 12'h000, 12'h654, 12'h000}, 1'b1);
        wait_bytes(base + 2);
        wr(8'd4, 16'h0000);
        exp_q.delete();
        wait_idle("en_off");
        chk("en_off_two_bytes", 16'(byte_cnt - base), 16'd2);
        base = byte_cnt;
        adc(48'h123_456_789_ABC, 1'b0);
        tick(20);
        chk("disabled_no_byte", 16'(byte_cnt - base), 16'd0);
        chk("disabled_busy", {15'd0, Busy}, 16'd0);
        chk("disabled_overrun", {15'd0, Overrun}, 16'd0);
        wr(8'd4, 16'h0001);

        // Empty mask: header only (+checksum)
        wr(8'd6, 16'h0000);
        cur_mask = 4'h0;
        base = byte_cnt;
        adc(48'h0, 1'b1);
        wait_idle("mask0");
`ifdef UART_FRAME_CKSUM_EN
        chk("mask0_len", 16'(byte_cnt - base), 16'd2);
`else
        chk("mask0_len", 16'(byte_cnt - base), 16'd1);
`endif

        // Reset mid-frame abandons the frame and restores defaults
        wr(8'd6, 16'h000F);
        cur_mask = 4'hF;
        base = byte_cnt;
        adc({12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD}, 1'b1);
        wait_bytes(base + 2);
        @(negedge Clk);
        Rst_n = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        chk("mid_rst_byte_en", {15'd0, Byte_En}, 16'd0);
        chk("mid_rst_tx_data", {8'd0, Tx_Data}, 16'd0);
        chk("mid_rst_baud", {13'd0, Baud_Set}, 16'd0);
        chk("mid_rst_busy", {15'd0, Busy}, 16'd0);
        Rst_n = 1'b1;
        tick(15);
        chk("post_rst_idle", {15'd0, Busy}, 16'd0);
        cur_mask = 4'hF;
        adc({12'h0F0, 12'h00F, 12'hF00, 12'h5A5}, 1'b1);
        wait_idle("post_rst_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
